// File: rtl/li_seq_pkg.sv
// Shared encodings for the load-immediate sequencer: extender modes, ALU
// operations, FSM states and the value classification.
package li_seq_pkg;

  typedef enum logic [1:0] {
    EXT_ZERO  = 2'b00,
    EXT_SIGN  = 2'b01,
    EXT_UPPER = 2'b10
  } ext_sel_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_OR  = 2'b01
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ISSUE1 = 2'b01,
    S_ISSUE2 = 2'b10,
    S_DONE   = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    SINGLE_ORI   = 2'b00,
    SINGLE_ADDIU = 2'b01,
    SINGLE_LUI   = 2'b10,
    PAIR         = 2'b11
  } li_class_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/li_value_classifier.sv
// Picks the shortest legal immediate sequence for a 2*IMM_W-bit constant.
module li_value_classifier
  import li_seq_pkg::*;
#(
  parameter int IMM_W = 16
) (
  input  logic [2*IMM_W-1:0] value,
  output li_class_t          cls
);

  logic [IMM_W-1:0] hi;
  logic [IMM_W-1:0] lo;

  assign hi = value[2*IMM_W-1:IMM_W];
  assign lo = value[IMM_W-1:0];

  // Priority order matters: zero upper half wins first (covers value 0),
  // then a sign-extendable negative, then a pure upper-half constant.
  always_comb begin
    if (hi == '0) begin
      cls = SINGLE_ORI;
    end else if ((hi == '1) && lo[IMM_W-1]) begin
      cls = SINGLE_ADDIU;
    end else if (lo == '0) begin
      cls = SINGLE_LUI;
    end else begin
      cls = PAIR;
    end
  end

endmodule

// File: rtl/load_immediate_sequencer.sv
// Expands an 'li' request into one or two immediate operations on the shared
// single-cycle datapath, issuing each only when the slot is granted.
module load_immediate_sequencer
  import li_seq_pkg::*;
#(
  parameter int IMM_W = 16,
  parameter int REG_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic [2*IMM_W-1:0] req_value,
  input  logic [REG_W-1:0]   req_rt,
  output logic               ready,
  input  logic               dp_grant,
  output logic [IMM_W-1:0]   imm_16bit,
  output logic [1:0]         ext_sel,
  output logic [REG_W-1:0]   src_rs,
  output logic [1:0]         alu_op,
  output logic               reg_write,
  output logic [REG_W-1:0]   write_reg,
  output logic               done
);

  state_t             state;
  state_t             state_next;
  li_class_t          cls_d;
  li_class_t          cls_q;
  logic [2*IMM_W-1:0] value_q;
  logic [REG_W-1:0]   rt_q;
  logic               accept;
  logic               rt_is_zero;

  assign accept     = (state == S_IDLE) && req;
  assign rt_is_zero = (req_rt == REG_W'(REG_ZERO));

  li_value_classifier #(.IMM_W(IMM_W)) u_classifier (
    .value (req_value),
    .cls   (cls_d)
  );

  // State register and request capture; the latched copy isolates the
  // sequence from any input changes while it runs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the latched request is reset too so a stale
  // value can never be presented after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      value_q <= '0;
      rt_q    <= '0;
      cls_q   <= SINGLE_ORI;
    end else begin
      state <= state_next;
      if (accept) begin
        value_q <= req_value;
        rt_q    <= req_rt;
        cls_q   <= cls_d;
      end
    end
  end

  // Next-state and datapath-control decode; reg_write follows dp_grant
  // combinationally so a write happens only in the granted cycle.
  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    state_next = state;
    ready      = (state == S_IDLE);
    done       = (state == S_DONE);
    imm_16bit  = '0;
    ext_sel    = EXT_ZERO;
    src_rs     = '0;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    write_reg  = '0;

    case (state)
      S_IDLE: begin
        if (req) begin
          state_next = rt_is_zero ? S_DONE : S_ISSUE1;
        end
      end

      S_ISSUE1: begin
        reg_write = dp_grant;
        write_reg = rt_q;
        case (cls_q)
          SINGLE_ORI: begin
            imm_16bit = value_q[IMM_W-1:0];
            ext_sel   = EXT_ZERO;
            alu_op    = ALU_OR;
          end
          SINGLE_ADDIU: begin
            imm_16bit = value_q[IMM_W-1:0];
            ext_sel   = EXT_SIGN;
            alu_op    = ALU_ADD;
          end
          default: begin
            // SINGLE_LUI and the first half of PAIR load the upper half.
            imm_16bit = value_q[2*IMM_W-1:IMM_W];
            ext_sel   = EXT_UPPER;
            alu_op    = ALU_ADD;
          end
        endcase
        if (dp_grant) begin
          state_next = (cls_q == PAIR) ? S_ISSUE2 : S_DONE;
        end
      end

      S_ISSUE2: begin
        // ORI the low half into the register the LUI just wrote.
        reg_write = dp_grant;
        write_reg = rt_q;
        imm_16bit = value_q[IMM_W-1:0];
        ext_sel   = EXT_ZERO;
        alu_op    = ALU_OR;
        src_rs    = rt_q;
        if (dp_grant) begin
          state_next = S_DONE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule
